// File: rtl/uart_stream_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO, integrated
// baud divider, back-to-back frames with no idle gap while the FIFO holds data.
module uart_stream_tx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_uart_tx;
    logic            r_busy;
    logic            r_tx_done;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_tx_ready;

    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;
    logic [LW-1:0]   w_level_nxt;
    logic [7:0]      w_rd_data;

    assign w_push    = tx_valid && r_tx_ready;
    assign w_bit_end = (r_cnt == CNT_LAST);
    // The FSM only ever dequeues when it is about to emit a start bit.
    assign w_pop     = (r_level != {LW{1'b0}}) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_rd_data = r_mem[r_rd_ptr];

    // Next FIFO occupancy from the push/pop pair of this cycle.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO storage; contents are meaningless until written so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, level and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_level    <= {LW{1'b0}};
            r_tx_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_tx_ready <= (w_level_nxt != LVL_FULL);
        end
    end

    // Frame sequencer; the line, busy and done flags are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_uart_tx <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= {CW{1'b0}};
                    r_bit_idx <= 3'd0;
                    r_tx_done <= 1'b0;
                    if (w_pop) begin
                        r_shift   <= w_rd_data;
                        r_state   <= S_START;
                        r_uart_tx <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_uart_tx <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                S_START: begin
                    r_tx_done <= 1'b0;
                    if (w_bit_end) begin
                        r_cnt     <= {CW{1'b0}};
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                        r_uart_tx <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    r_tx_done <= 1'b0;
                    if (w_bit_end) begin
                        r_cnt <= {CW{1'b0}};
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= S_STOP;
                            r_uart_tx <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_uart_tx <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Raised one edge early so the pulse covers the final stop cycle.
                    r_tx_done <= (r_cnt == CNT_PRE);
                    if (w_bit_end) begin
                        r_cnt <= {CW{1'b0}};
                        if (w_pop) begin
                            r_shift   <= w_rd_data;
                            r_state   <= S_START;
                            r_uart_tx <= 1'b0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_uart_tx <= 1'b1;
                            r_busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= {CW{1'b0}};
                    r_bit_idx <= 3'd0;
                    r_uart_tx <= 1'b1;
                    r_busy    <= 1'b0;
                    r_tx_done <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = r_tx_ready;
    assign uart_tx    = r_uart_tx;
    assign tx_busy    = r_busy;
    assign tx_done    = r_tx_done;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: three instances (default 217-cycle bits, 2500-cycle
// bits, 10-cycle bits) checked against ideal 8N1 waveforms and a line receiver.
module tb_uart_stream_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data    [3];
    logic       tx_valid   [3];
    logic       tx_ready   [3];
    logic       uart_tx    [3];
    logic       tx_busy    [3];
    logic       tx_done    [3];
    logic [4:0] fifo_level [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] src [64];
    logic [7:0] rx_q [$];
    int         starts = 0;

    always #5 clk = ~clk;

    uart_stream_tx u_def (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .uart_tx(uart_tx[0]), .tx_busy(tx_busy[0]),
        .tx_done(tx_done[0]), .fifo_level(fifo_level[0])
    );

    uart_stream_tx #(.CLK_FREQ(24000000), .BAUD(9600)) u_slow (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .uart_tx(uart_tx[1]), .tx_busy(tx_busy[1]),
        .tx_done(tx_done[1]), .fifo_level(fifo_level[1])
    );

    uart_stream_tx #(.CLK_FREQ(1000000), .BAUD(100000)) u_fast (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .uart_tx(uart_tx[2]), .tx_busy(tx_busy[2]),
        .tx_done(tx_done[2]), .fifo_level(fifo_level[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called on the first cycle of a start bit; checks every cycle of the frame.
    task automatic check_frame(input int k, input int div, input logic [7:0] b);
        for (int i = 0; i < 10 * div; i++) begin
            int   bi;
            logic e;
            bi = i / div;
            if (bi == 0)      e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else              e = b[bi-1];
            check("frame_line", uart_tx[k], e);
            check("frame_done", tx_done[k], (i == 10 * div - 1));
            check("frame_busy", tx_busy[k], 1'b1);
            tick();
        end
    endtask

    task automatic check_idle(input int k);
        check("idle_line", uart_tx[k], 1'b1);
        check("idle_busy", tx_busy[k], 1'b0);
        check("idle_done", tx_done[k], 1'b0);
        check("idle_level", fifo_level[k], 0);
    endtask

    // Push n bytes from src into the fast instance and compare what the receiver decodes.
    task automatic stream(input int n, input bit gaps);
        int accepted = 0;
        int base;
        int idx = 0;
        int pend_idx = 0;
        int exp_lvl;
        bit pending = 1'b0;
        bit saw_full = 1'b0;
        rx_q.delete();
        base = starts;
        for (int c = 0; c < n * 100 + 500 && rx_q.size() < n; c++) begin
            tick();
            if (pending) accepted++;
            exp_lvl = accepted - (starts - base);
            check("stream_level", fifo_level[2], exp_lvl);
            check("stream_level_max", (fifo_level[2] <= 5'd16), 1'b1);
            check("stream_ready", tx_ready[2], (exp_lvl != 16));
            if (pending && !gaps && pend_idx == n - 1) check("last_push_level", fifo_level[2], 16);
            if (exp_lvl == 16) saw_full = 1'b1;
            if (idx < n) begin
                tx_data[2]  = src[idx];
                tx_valid[2] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                pending     = tx_valid[2] && tx_ready[2];
                pend_idx    = idx;
                if (pending) idx++;
            end else begin
                tx_valid[2] = 1'b0;
                pending     = 1'b0;
            end
        end
        tx_valid[2] = 1'b0;
        check("stream_count", rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) check("stream_byte", rx_q[i], src[i]);
        if (!gaps) check("stream_saw_full", saw_full, 1'b1);
    endtask

    // Line receiver for the fast instance (10 cycles per bit), sampling mid-bit.
    initial begin
        bit         rx_active = 1'b0;
        int         rx_pos = 0;
        logic [7:0] rx_sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (uart_tx[2] === 1'b0) begin
                    rx_active = 1'b1;
                    rx_pos    = 0;
                    starts++;
                end
            end else begin
                rx_pos++;
                if (rx_pos % 10 == 5) begin
                    int bi;
                    bi = rx_pos / 10;
                    if (bi == 0) check("rx_start", uart_tx[2], 1'b0);
                    else if (bi <= 8) rx_sh[bi-1] = uart_tx[2];
                    else begin
                        check("rx_stop", uart_tx[2], 1'b1);
                        rx_q.push_back(rx_sh);
                    end
                end
                if (rx_pos == 99) rx_active = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_valid[k] = 1'b1;
            tx_data[k]  = 8'hFF;
        end
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_line", uart_tx[k], 1'b1);
            check("rst_ready", tx_ready[k], 1'b1);
            check("rst_level", fifo_level[k], 0);
            check("rst_busy", tx_busy[k], 1'b0);
            check("rst_done", tx_done[k], 1'b0);
        end
        for (int k = 0; k < 3; k++) tx_valid[k] = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        // Single byte 0x55 at 217 cycles per bit.
        tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        check("single_level_after_push", fifo_level[0], 1);
        check("single_line_before_start", uart_tx[0], 1'b1);
        tick();
        check("single_level_after_pop", fifo_level[0], 0);
        check_frame(0, 217, 8'h55);
        check_idle(0);

        // Back-to-back frames.
        tx_data[0] = 8'hA3; tx_valid[0] = 1'b1;
        tick();
        tx_data[0] = 8'h0F;
        tick();
        tx_valid[0] = 1'b0;
        check("b2b_level", fifo_level[0], 1);
        check_frame(0, 217, 8'hA3);
        check_frame(0, 217, 8'h0F);
        check_idle(0);

        // Reset in the middle of data bit 0 of 0x3C (a low bit), second byte queued.
        tx_data[0] = 8'h3C; tx_valid[0] = 1'b1;
        tick();
        tx_data[0] = 8'hC3;
        tick();
        tx_valid[0] = 1'b0;
        repeat (217 + 100) tick();
        check("mid_line_low", uart_tx[0], 1'b0);
        check("mid_level", fifo_level[0], 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_line", uart_tx[0], 1'b1);
        check("mid_rst_level", fifo_level[0], 0);
        check("mid_rst_busy", tx_busy[0], 1'b0);
        check("mid_rst_ready", tx_ready[0], 1'b1);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_idle(0);

        // 2500 cycles per bit.
        tx_data[1] = 8'h96; tx_valid[1] = 1'b1;
        tick();
        tx_valid[1] = 1'b0;
        tick();
        check_frame(1, 2500, 8'h96);
        check_idle(1);

        // Fill with 17 sequential bytes, valid held high.
        for (int i = 0; i < 17; i++) src[i] = 8'(i);
        stream(17, 1'b0);
        repeat (120) tick();
        check_idle(2);

        // Random bytes with random valid gaps.
        for (int i = 0; i < 40; i++) src[i] = 8'($urandom);
        stream(40, 1'b1);
        repeat (120) tick();
        check_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
